// File: rtl/pipe_stall_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl_pkg
//   Shared definitions for the pipeline stall controller: stop/no-stop
//   levels, the four legal stall-vector encodings and the multi-cycle
//   sequencer state codes.
//   Stall vector bit order: [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB.
// ---------------------------------------------------------------------------
package pipe_stall_ctrl_pkg;

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    // Each encoding freezes every stage up to and including the requester;
    // the register just past the boundary inserts a bubble.
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    typedef enum logic {
        SEQ_IDLE = 1'b0,
        SEQ_BUSY = 1'b1
    } seq_state_e;

endpackage

// File: rtl/pipe_stall_ctrl_ex_multi_seq.sv
// ---------------------------------------------------------------------------
// ex_multi_seq
//   Sequencer for multi-cycle EX operations (mult/div). Holds EX for N-1
//   cycles that are not frozen by a MEM stall, then flags the final cycle.
// Ports
//   clk           in   system clock
//   rst           in   synchronous active-high reset
//   i_flush       in   abort any operation in flight
//   i_hold        in   MEM stall: EX is frozen, countdown does not advance
//   i_start       in   EX issues a multi-cycle op this cycle
//   i_cycles      in   total EX occupancy N of the op
//   o_seq_stall   out  sequencer request to stall EX (combinational)
//   o_busy        out  sequencer is in BUSY (registered state)
//   o_done        out  final EX cycle of the op (combinational)
// ---------------------------------------------------------------------------
module ex_multi_seq
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_hold,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_cycles,
    output logic             o_seq_stall,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    seq_state_e       r_state;
    seq_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SEQ_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        o_seq_stall = 1'b0;
        o_done      = 1'b0;
        // Reset gates the combinational outputs so nothing leaks before the
        // state register has been initialised.
        if (rst || i_flush) begin
            w_state_nxt = SEQ_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                SEQ_IDLE: begin
                    if (i_start) begin
                        if (i_cycles <= ONE) begin
                            // Single-cycle op: result is ready immediately.
                            o_done = 1'b1;
                        end else begin
                            // This cycle is the first held cycle.
                            o_seq_stall = 1'b1;
                            w_cnt_nxt   = i_cycles - ONE;
                            w_state_nxt = SEQ_BUSY;
                        end
                    end
                end
                SEQ_BUSY: begin
                    o_seq_stall = (r_cnt > ONE);
                    o_done      = (r_cnt == ONE);
                    // A frozen EX does not consume an op cycle; at cnt==1 this
                    // keeps done asserted until MEM releases.
                    if (!i_hold) begin
                        w_cnt_nxt = r_cnt - ONE;
                        if (r_cnt == ONE) begin
                            w_state_nxt = SEQ_IDLE;
                        end
                    end
                end
                default: begin
                    w_state_nxt = SEQ_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign o_busy = (r_state == SEQ_BUSY);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl
//   Central stall controller for the 5-stage pipeline. Merges ID/EX/MEM stall
//   requests into the 6-bit stall vector, sequences multi-cycle EX ops and
//   counts stalled cycles for the performance register.
// Ports
//   clk              in   system clock
//   rst              in   synchronous active-high reset (wins over flush)
//   flush            in   pipeline flush; aborts multi-cycle op
//   stallreq_id      in   ID hazard request (load-use)
//   stallreq_ex      in   EX external request
//   stallreq_mem     in   MEM waiting on data memory
//   ex_multi_start   in   EX issues a multi-cycle op this cycle
//   ex_multi_cycles  in   total EX occupancy N of that op
//   stall            out  [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB, 1 = stop
//   ex_multi_busy    out  sequencer in BUSY
//   ex_multi_done    out  final EX cycle of multi-cycle op
//   stall_cycles     out  saturating count of cycles with stall[0] set
// ---------------------------------------------------------------------------
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int CNT_W  = 6,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              stallreq_id,
    input  logic              stallreq_ex,
    input  logic              stallreq_mem,
    input  logic              ex_multi_start,
    input  logic [CNT_W-1:0]  ex_multi_cycles,
    output logic [5:0]        stall,
    output logic              ex_multi_busy,
    output logic              ex_multi_done,
    output logic [PERF_W-1:0] stall_cycles
);

    logic              w_seq_stall;
    logic              w_ex_req;
    logic [PERF_W-1:0] r_stall_cycles;

    ex_multi_seq #(
        .CNT_W (CNT_W)
    ) u_seq (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (flush),
        .i_hold      (stallreq_mem),
        .i_start     (ex_multi_start),
        .i_cycles    (ex_multi_cycles),
        .o_seq_stall (w_seq_stall),
        .o_busy      (ex_multi_busy),
        .o_done      (ex_multi_done)
    );

    assign w_ex_req = stallreq_ex | w_seq_stall;

    // Deepest requesting stage wins; a flush discards the stall so the
    // redirected fetch proceeds immediately.
    always_comb begin
        stall = STALL_NONE;
        if (rst || flush) begin
            stall = STALL_NONE;
        end else if (stallreq_mem) begin
            stall = STALL_MEM;
        end else if (w_ex_req) begin
            stall = STALL_EX;
        end else if (stallreq_id) begin
            stall = STALL_ID;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if ((stall[0] == STOP) && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + PERF_W'(1);
        end
    end

    assign stall_cycles = r_stall_cycles;

endmodule
